// File: rtl/timer_field_counter_if.sv
// Control/status bundle for one timer field: stimulus side is master, counter is slave.
interface timer_field_counter_if #(parameter int WIDTH = 6);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic             dir;
  logic             tick_in;
  logic             upper_zero;
  logic [WIDTH-1:0] value;
  logic             tick_out;
  logic             at_zero;
  logic             done;
  logic [1:0]       state;

  modport master (
    output load, load_val, start, pause, dir, tick_in, upper_zero,
    input  value, tick_out, at_zero, done, state
  );

  modport slave (
    input  load, load_val, start, pause, dir, tick_in, upper_zero,
    output value, tick_out, at_zero, done, state
  );
endinterface

// File: rtl/timer_field_counter.sv
// Modulo-(MAX+1) up/down field counter with run/pause/done sequencing; value updates one edge after tick_in, tick_out is same-cycle.
// Build option TIMER_FIELD_AUTORELOAD_EN: countdown expiry reloads the last loaded value and keeps running.
module timer_field_counter #(
  parameter int WIDTH = 6,
  parameter int MAX   = 59
) (
  input  logic                  clk,
  input  logic                  rst_n,
  timer_field_counter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_e;

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  state_e           state_q;
  logic [WIDTH-1:0] value_q;
  logic             done_q;
  logic [WIDTH-1:0] load_clamped;
  logic             at_zero;
  logic             wrap_up;
  logic             wrap_dn;

  assign load_clamped = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
  assign at_zero      = (value_q == '0);
  assign wrap_up      = (value_q == MAX_V);
  assign wrap_dn      = at_zero & ~bus.upper_zero;

  // Combinational so a whole chain of fields advances on the same edge.
  assign bus.tick_out = (state_q == RUN) & bus.tick_in & ~bus.pause &
                        (bus.dir ? wrap_up : wrap_dn);
  assign bus.at_zero  = at_zero;
  assign bus.value    = value_q;
  assign bus.done     = done_q;
  assign bus.state    = state_q;

`ifdef TIMER_FIELD_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q  <= '0;
      state_q  <= IDLE;
      done_q   <= 1'b0;
`ifdef TIMER_FIELD_AUTORELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (bus.pause) begin
            state_q <= PAUSE;
          end else if (bus.tick_in) begin
            if (bus.dir) begin
              value_q <= wrap_up ? '0 : value_q + WIDTH'(1);
            end else if (!at_zero) begin
              value_q <= value_q - WIDTH'(1);
            end else if (!bus.upper_zero) begin
              value_q <= MAX_V;
            end else begin
              done_q <= 1'b1;
`ifdef TIMER_FIELD_AUTORELOAD_EN
              value_q <= reload_q;
              if (reload_q == '0) state_q <= DONE;
`else
              state_q <= DONE;
`endif
            end
          end
        end
        // IDLE, PAUSE, DONE: pause only matters while running; load beats start.
        default: begin
          if (bus.load) begin
            value_q <= load_clamped;
`ifdef TIMER_FIELD_AUTORELOAD_EN
            reload_q <= load_clamped;
`endif
            if (state_q == DONE) state_q <= IDLE;
          end else if (bus.start) begin
            state_q <= RUN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_field_counter.sv
// Directed bench: a seconds field cascaded into a minutes field (top, upper_zero tied 1).
module tb_timer_field_counter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  timer_field_counter_if #(.WIDTH(6)) s_if ();
  timer_field_counter_if #(.WIDTH(6)) m_if ();

  timer_field_counter #(.WIDTH(6), .MAX(59)) u_sec (.clk(clk), .rst_n(rst_n), .bus(s_if));
  timer_field_counter #(.WIDTH(6), .MAX(59)) u_min (.clk(clk), .rst_n(rst_n), .bus(m_if));

  assign m_if.tick_in    = s_if.tick_out;
  assign s_if.upper_zero = m_if.at_zero;

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_if.load = 0; s_if.load_val = '0; s_if.start = 0; s_if.pause = 0; s_if.dir = 0; s_if.tick_in = 0;
    m_if.load = 0; m_if.load_val = '0; m_if.start = 0; m_if.pause = 0; m_if.dir = 0; m_if.upper_zero = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    cyc();
    rst_n = 1;
    cyc();
  endtask

  task automatic sec_load_start(input logic [5:0] v);
    s_if.load = 1; s_if.load_val = v; cyc(); s_if.load = 0;
    s_if.start = 1; cyc(); s_if.start = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    cyc(); cyc();
    tests++; if (s_if.value !== 6'd0) begin fails++; $display("FAIL reset_value: got %0d expected 0", s_if.value); end
    tests++; if (s_if.state !== 2'b00) begin fails++; $display("FAIL reset_state: got %b expected 00", s_if.state); end
    tests++; if (s_if.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", s_if.done); end
    tests++; if (s_if.at_zero !== 1'b1) begin fails++; $display("FAIL reset_at_zero: got %b expected 1", s_if.at_zero); end
    tests++; if (s_if.tick_out !== 1'b0) begin fails++; $display("FAIL reset_tick_out: got %b expected 0", s_if.tick_out); end
    rst_n = 1;
    cyc();
  endtask

  task automatic test_countdown();
    do_reset();
    s_if.load = 1; s_if.load_val = 6'd5; cyc(); s_if.load = 0;
    tests++; if (s_if.value !== 6'd5 || s_if.state !== 2'b00) begin fails++; $display("FAIL cd_load: got %0d/%b expected 5/00", s_if.value, s_if.state); end
    s_if.start = 1; cyc(); s_if.start = 0;
    tests++; if (s_if.state !== 2'b01) begin fails++; $display("FAIL cd_start: got %b expected 01", s_if.state); end
    for (int i = 0; i < 5; i++) begin
      s_if.tick_in = 1; cyc();
      tests++; if (s_if.value !== 6'(4 - i)) begin fails++; $display("FAIL cd_tick%0d: got %0d expected %0d", i, s_if.value, 4 - i); end
    end
    #1;
    tests++; if (s_if.tick_out !== 1'b0) begin fails++; $display("FAIL cd_expiry_tick_out: got %b expected 0", s_if.tick_out); end
    cyc(); s_if.tick_in = 0;
`ifdef TIMER_FIELD_AUTORELOAD_EN
    tests++; if (s_if.done !== 1'b1 || s_if.value !== 6'd5 || s_if.state !== 2'b01) begin fails++; $display("FAIL cd_reload: got done=%b value=%0d state=%b expected 1/5/01", s_if.done, s_if.value, s_if.state); end
    cyc();
    tests++; if (s_if.done !== 1'b0) begin fails++; $display("FAIL cd_done_pulse: got %b expected 0", s_if.done); end
`else
    tests++; if (s_if.done !== 1'b1 || s_if.value !== 6'd0 || s_if.state !== 2'b11) begin fails++; $display("FAIL cd_expiry: got done=%b value=%0d state=%b expected 1/0/11", s_if.done, s_if.value, s_if.state); end
    s_if.tick_in = 1; cyc(); s_if.tick_in = 0;
    tests++; if (s_if.done !== 1'b0 || s_if.state !== 2'b11 || s_if.value !== 6'd0) begin fails++; $display("FAIL cd_done_hold: got done=%b value=%0d state=%b expected 0/0/11", s_if.done, s_if.value, s_if.state); end
    s_if.load = 1; s_if.load_val = 6'd9; cyc(); s_if.load = 0;
    tests++; if (s_if.value !== 6'd9 || s_if.state !== 2'b00) begin fails++; $display("FAIL cd_done_load: got %0d/%b expected 9/00", s_if.value, s_if.state); end
`endif
  endtask

  task automatic test_cascade();
    do_reset();
    m_if.load = 1; m_if.load_val = 6'd3; cyc(); m_if.load = 0;
    s_if.start = 1; m_if.start = 1; cyc(); s_if.start = 0; m_if.start = 0;
    s_if.tick_in = 1; #1;
    tests++; if (s_if.tick_out !== 1'b1) begin fails++; $display("FAIL cas_tick_out: got %b expected 1", s_if.tick_out); end
    cyc(); s_if.tick_in = 0;
    tests++; if (s_if.value !== 6'd59) begin fails++; $display("FAIL cas_sec: got %0d expected 59", s_if.value); end
    tests++; if (m_if.value !== 6'd2) begin fails++; $display("FAIL cas_min: got %0d expected 2", m_if.value); end
    tests++; if (s_if.state !== 2'b01 || s_if.done !== 1'b0) begin fails++; $display("FAIL cas_state: got %b/%b expected 01/0", s_if.state, s_if.done); end
  endtask

  task automatic test_up();
    do_reset();
    sec_load_start(6'd58);
    s_if.dir = 1; s_if.tick_in = 1; #1;
    tests++; if (s_if.tick_out !== 1'b0) begin fails++; $display("FAIL up_no_carry: got %b expected 0", s_if.tick_out); end
    cyc();
    tests++; if (s_if.value !== 6'd59) begin fails++; $display("FAIL up_59: got %0d expected 59", s_if.value); end
    #1;
    tests++; if (s_if.tick_out !== 1'b1) begin fails++; $display("FAIL up_carry: got %b expected 1", s_if.tick_out); end
    cyc(); s_if.tick_in = 0; s_if.dir = 0;
    tests++; if (s_if.value !== 6'd0 || s_if.state !== 2'b01 || s_if.done !== 1'b0) begin fails++; $display("FAIL up_wrap: got %0d/%b/%b expected 0/01/0", s_if.value, s_if.state, s_if.done); end
  endtask

  task automatic test_pause();
    do_reset();
    sec_load_start(6'd10);
    s_if.pause = 1; s_if.tick_in = 1; cyc(); s_if.pause = 0; s_if.tick_in = 0;
    tests++; if (s_if.value !== 6'd10 || s_if.state !== 2'b10) begin fails++; $display("FAIL pause_freeze: got %0d/%b expected 10/10", s_if.value, s_if.state); end
    s_if.tick_in = 1; cyc(); s_if.tick_in = 0;
    tests++; if (s_if.value !== 6'd10) begin fails++; $display("FAIL pause_tick: got %0d expected 10", s_if.value); end
    s_if.load = 1; s_if.load_val = 6'd40; cyc(); s_if.load = 0;
    tests++; if (s_if.value !== 6'd40 || s_if.state !== 2'b10) begin fails++; $display("FAIL pause_load: got %0d/%b expected 40/10", s_if.value, s_if.state); end
    s_if.start = 1; cyc(); s_if.start = 0;
    s_if.tick_in = 1; cyc(); s_if.tick_in = 0;
    tests++; if (s_if.value !== 6'd39 || s_if.state !== 2'b01) begin fails++; $display("FAIL pause_resume: got %0d/%b expected 39/01", s_if.value, s_if.state); end
  endtask

  task automatic test_clamp();
    do_reset();
    s_if.load = 1; s_if.load_val = 6'd63; cyc(); s_if.load = 0;
    tests++; if (s_if.value !== 6'd59) begin fails++; $display("FAIL clamp_63: got %0d expected 59", s_if.value); end
    s_if.load = 1; s_if.load_val = 6'd60; cyc(); s_if.load = 0;
    tests++; if (s_if.value !== 6'd59) begin fails++; $display("FAIL clamp_60: got %0d expected 59", s_if.value); end
    sec_load_start(6'd20);
    s_if.load = 1; s_if.load_val = 6'd7; cyc(); s_if.load = 0;
    tests++; if (s_if.value !== 6'd20 || s_if.state !== 2'b01) begin fails++; $display("FAIL run_load_ignored: got %0d/%b expected 20/01", s_if.value, s_if.state); end
  endtask

  task automatic test_async_reset();
    do_reset();
    sec_load_start(6'd31);
    s_if.tick_in = 1; cyc();
    tests++; if (s_if.value !== 6'd30) begin fails++; $display("FAIL ar_pre: got %0d expected 30", s_if.value); end
    #2; rst_n = 0; #1;
    tests++; if (s_if.value !== 6'd0 || s_if.state !== 2'b00 || s_if.at_zero !== 1'b1) begin fails++; $display("FAIL ar_abort: got %0d/%b/%b expected 0/00/1", s_if.value, s_if.state, s_if.at_zero); end
    s_if.tick_in = 0;
    cyc(); rst_n = 1; cyc();
    tests++; if (s_if.done !== 1'b0 || s_if.state !== 2'b00) begin fails++; $display("FAIL ar_no_done: got %b/%b expected 0/00", s_if.done, s_if.state); end
  endtask

`ifdef TIMER_FIELD_AUTORELOAD_EN
  task automatic test_autoreload();
    do_reset();
    sec_load_start(6'd3);
    s_if.tick_in = 1; cyc(); cyc(); cyc(); cyc(); s_if.tick_in = 0;
    tests++; if (s_if.done !== 1'b1 || s_if.value !== 6'd3 || s_if.state !== 2'b01) begin fails++; $display("FAIL arl_reload3: got %b/%0d/%b expected 1/3/01", s_if.done, s_if.value, s_if.state); end
    do_reset();
    s_if.start = 1; cyc(); s_if.start = 0;
    s_if.tick_in = 1; cyc(); s_if.tick_in = 0;
    tests++; if (s_if.done !== 1'b1 || s_if.state !== 2'b11) begin fails++; $display("FAIL arl_zero_done: got %b/%b expected 1/11", s_if.done, s_if.state); end
  endtask
`endif

  initial begin
    test_reset();
    test_countdown();
    test_cascade();
    test_up();
    test_pause();
    test_clamp();
    test_async_reset();
`ifdef TIMER_FIELD_AUTORELOAD_EN
    test_autoreload();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
